// File: rtl/dcache_miss_ctrl_if.sv
// Memory-side request/response bus of the data-cache miss controller.
// The controller owns the request channel; read responses return in order.
interface dcache_miss_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss handler: dirty-victim writeback then in-order line refill.
// Stalls the pipeline from the missing IDLE cycle until the DONE pulse; requests hold while not ready.
module dcache_miss_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         flush,
  input  logic                         r_valid,
  input  logic                         w_valid,
  input  logic [ADDR_W-1:0]            Addr,
  input  logic                         hit_i,
  input  logic                         victim_dirty_i,
  input  logic [ADDR_W-1:0]            victim_addr_i,
  input  logic [LINE_WORDS*DATA_W-1:0] victim_data_i,
  output logic                         stall_o,
  dcache_miss_ctrl_if.master           mem,
  output logic                         refill_we_o,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word_o,
  output logic [DATA_W-1:0]            refill_data_o,
  output logic                         line_done_o,
  output logic [ADDR_W-1:0]            line_addr_o
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

  typedef enum logic [2:0] {IDLE, WB, FILL_REQ, FILL_WAIT, DONE} state_t;

  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic [ADDR_W-1:0]           base_q;
  logic [ADDR_W-1:0]           vaddr_q;
  logic [LINE_WORDS*DATA_W-1:0] vdata_q;

  logic miss;
  logic last_word;
  logic [CW-1:0] cnt_d;

  assign miss      = (r_valid | w_valid) & ~hit_i & ~flush;
  assign last_word = (cnt_q == CW'(LINE_WORDS - 1));
  assign cnt_d     = last_word ? '0 : cnt_q + 1'b1;

  // Reset gating keeps every output low while RESET is asserted, even with a pending access.
  assign stall_o = RESET & ((state_q != IDLE) | miss);

  assign mem.mem_req_valid = (state_q == WB) | (state_q == FILL_REQ);
  assign mem.mem_req_write = (state_q == WB);
  assign mem.mem_req_addr  = !mem.mem_req_valid ? '0 :
                             ((state_q == WB) ? vaddr_q : base_q) + (ADDR_W'(cnt_q) << 2);
  assign mem.mem_req_wdata = (state_q == WB) ? vdata_q[cnt_q*DATA_W +: DATA_W] : '0;

  assign refill_we_o   = (state_q == FILL_WAIT) & mem.mem_rsp_valid;
  assign refill_word_o = refill_we_o ? cnt_q : '0;
  assign refill_data_o = refill_we_o ? mem.mem_rsp_data : '0;

  assign line_done_o = (state_q == DONE);
  assign line_addr_o = (state_q != IDLE) ? base_q : '0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      vaddr_q <= '0;
      vdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            base_q  <= Addr & LINE_MASK;
            vaddr_q <= victim_addr_i;
            vdata_q <= victim_data_i;
            cnt_q   <= '0;
            state_q <= victim_dirty_i ? WB : FILL_REQ;
          end
        end
        WB: begin
          // Writes are posted: the refill starts as soon as the last word is accepted.
          if (mem.mem_req_ready) begin
            cnt_q <= cnt_d;
            if (last_word) state_q <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem.mem_req_ready) state_q <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (mem.mem_rsp_valid) begin
            cnt_q   <= cnt_d;
            state_q <= last_word ? DONE : FILL_REQ;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: transaction-level scoreboard plus literal spot checks.
module tb_dcache_miss_ctrl;
  logic         CLK = 1'b0;
  logic         RESET;
  logic         flush, r_valid, w_valid, hit_i, victim_dirty_i;
  logic [31:0]  Addr, victim_addr_i;
  logic [127:0] victim_data_i;
  logic         stall_o, refill_we_o, line_done_o;
  logic [1:0]   refill_word_o;
  logic [31:0]  refill_data_o, line_addr_o;

  dcache_miss_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  dcache_miss_ctrl #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush), .r_valid(r_valid), .w_valid(w_valid),
    .Addr(Addr), .hit_i(hit_i), .victim_dirty_i(victim_dirty_i),
    .victim_addr_i(victim_addr_i), .victim_data_i(victim_data_i), .stall_o(stall_o),
    .mem(mem_if), .refill_we_o(refill_we_o), .refill_word_o(refill_word_o),
    .refill_data_o(refill_data_o), .line_done_o(line_done_o), .line_addr_o(line_addr_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct packed { logic [1:0] word; logic [31:0] data; } fill_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model state: what memory traffic and refill writes the current miss must produce.
  req_t        exp_req[$];
  fill_t       exp_fill[$];
  logic        busy = 1'b0;
  logic [31:0] exp_base = '0;
  logic        hold_q = 1'b0;
  req_t        hold_r;
  int          n_rd_acc = 0;
  logic        first_pending = 1'b0;
  logic [31:0] first_addr = '0, first_wdata = '0, last_fill_data = '0, last_done_addr = '0;

  // Memory responder state.
  logic        rd_pend = 1'b0;
  logic [1:0]  rd_idx = '0;
  logic [31:0] rsp_base = '0;
  logic [31:0] bp_addr = '0;
  int          bp_left = 0;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      mem_if.mem_rsp_valid = rd_pend;
      mem_if.mem_rsp_data  = rd_pend ? rsp_base + 32'(rd_idx) : 32'd0;
      rd_pend = 1'b0;
      if (bp_left > 0 && mem_if.mem_req_valid && mem_if.mem_req_write &&
          mem_if.mem_req_addr == bp_addr) begin
        mem_if.mem_req_ready = 1'b0;
        bp_left--;
      end else begin
        mem_if.mem_req_ready = 1'b1;
      end
    end
  end

  initial begin
    logic b0, miss_now;
    req_t cur, e;
    fill_t f;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        chk("reset_outputs_zero", 64'(|{stall_o, mem_if.mem_req_valid, mem_if.mem_req_write,
            mem_if.mem_req_addr, mem_if.mem_req_wdata, refill_we_o, refill_word_o,
            refill_data_o, line_done_o, line_addr_o}), 64'd0);
        exp_req.delete();
        exp_fill.delete();
        busy = 1'b0;
        hold_q = 1'b0;
        rd_pend = 1'b0;
      end else begin
        b0 = busy;
        miss_now = (r_valid | w_valid) & ~hit_i & ~flush;
        chk("stall", 64'(stall_o), 64'(b0 | miss_now));
        if (!b0) chk("idle_no_req", 64'(mem_if.mem_req_valid), 64'd0);
        cur = '{wr: mem_if.mem_req_write, addr: mem_if.mem_req_addr, wdata: mem_if.mem_req_wdata};
        if (hold_q) begin
          chk("hold_valid", 64'(mem_if.mem_req_valid), 64'd1);
          chk("hold_req", 64'(cur.wr), 64'(hold_r.wr));
          chk("hold_addr", 64'(cur.addr), 64'(hold_r.addr));
          chk("hold_wdata", 64'(cur.wdata), 64'(hold_r.wdata));
        end
        if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
          if (exp_req.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
          else begin
            e = exp_req.pop_front();
            chk("req_write", 64'(cur.wr), 64'(e.wr));
            chk("req_addr", 64'(cur.addr), 64'(e.addr));
            chk("req_wdata", 64'(cur.wdata), 64'(e.wdata));
          end
          if (first_pending) begin
            first_addr = cur.addr;
            first_wdata = cur.wdata;
            first_pending = 1'b0;
          end
          if (!cur.wr) begin
            n_rd_acc++;
            rd_pend = 1'b1;
            rd_idx = cur.addr[3:2];
          end
        end
        hold_q = mem_if.mem_req_valid & ~mem_if.mem_req_ready;
        hold_r = cur;
        if (refill_we_o) begin
          if (exp_fill.size() == 0) chk("unexpected_refill", 64'd1, 64'd0);
          else begin
            f = exp_fill.pop_front();
            chk("refill_word", 64'(refill_word_o), 64'(f.word));
            chk("refill_data", 64'(refill_data_o), 64'(f.data));
          end
          last_fill_data = refill_data_o;
        end
        if (line_done_o) begin
          chk("done_expected", 64'(b0), 64'd1);
          chk("done_line_addr", 64'(line_addr_o), 64'(exp_base));
          chk("done_all_words", 64'(exp_req.size() + exp_fill.size()), 64'd0);
          last_done_addr = line_addr_o;
          busy = 1'b0;
        end else begin
          chk("line_addr", 64'(line_addr_o), b0 ? 64'(exp_base) : 64'd0);
        end
        if (!b0 && miss_now) begin
          exp_base = Addr & ~32'hF;
          if (victim_dirty_i)
            for (int i = 0; i < 4; i++)
              exp_req.push_back('{wr: 1'b1, addr: victim_addr_i + 32'(4 * i),
                                  wdata: victim_data_i[i*32 +: 32]});
          for (int i = 0; i < 4; i++) begin
            exp_req.push_back('{wr: 1'b0, addr: exp_base + 32'(4 * i), wdata: 32'd0});
            exp_fill.push_back('{word: 2'(i), data: rsp_base + 32'(i)});
          end
          busy = 1'b1;
          first_pending = 1'b1;
        end
      end
    end
  end

  task automatic run_miss(input logic rd, input logic [31:0] a, input logic dirty,
                          input logic [31:0] va, input logic [127:0] vd,
                          input logic [31:0] rb, input logic flush_mid, output int sc);
    logic done;
    int r0;
    @(posedge CLK);
    #1;
    rsp_base = rb;
    r_valid = rd; w_valid = ~rd; Addr = a; hit_i = 1'b0;
    victim_dirty_i = dirty; victim_addr_i = va; victim_data_i = vd;
    sc = 0;
    done = 1'b0;
    r0 = n_rd_acc;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge CLK);
      if (stall_o) sc++;
      if (line_done_o) done = 1'b1;
      if (flush_mid && n_rd_acc > r0) flush = 1'b1;
    end
    if (!done) chk("miss_timeout", 64'd0, 64'd1);
    @(posedge CLK);
    #1;
    hit_i = 1'b1;
    flush = 1'b0;
    @(posedge CLK);
    #1;
    r_valid = 1'b0; w_valid = 1'b0; hit_i = 1'b0;
  endtask

  initial begin
    int sc, r0;
    RESET = 1'b0; flush = 1'b0; r_valid = 1'b0; w_valid = 1'b0; hit_i = 1'b0;
    Addr = '0; victim_dirty_i = 1'b0; victim_addr_i = '0; victim_data_i = '0;
    mem_if.mem_req_ready = 1'b1; mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rsp_data = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;

    // Hit: no stall, no traffic.
    r_valid = 1'b1; hit_i = 1'b1; Addr = 32'h100;
    repeat (3) begin
      @(negedge CLK);
      chk("hit_no_stall", 64'(stall_o), 64'd0);
    end
    // Miss presented under flush must be ignored.
    @(posedge CLK);
    #1 hit_i = 1'b0; flush = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("flush_idle_no_stall", 64'(stall_o), 64'd0);
      chk("flush_idle_no_req", 64'(mem_if.mem_req_valid), 64'd0);
    end
    @(posedge CLK);
    #1 r_valid = 1'b0; flush = 1'b0;

    // Clean read miss: 1 IDLE + 2 per word + DONE.
    run_miss(1'b1, 32'h1234, 1'b0, 32'h0, 128'h0, 32'hA0, 1'b0, sc);
    chk("clean_stall_cycles", 64'(sc), 64'd10);
    chk("clean_first_addr", 64'(first_addr), 64'h1230);
    chk("clean_line_addr", 64'(last_done_addr), 64'h1230);
    chk("clean_last_fill", 64'(last_fill_data), 64'hA3);

    // Dirty store miss: four writebacks precede the refill.
    run_miss(1'b0, 32'h2468, 1'b1, 32'h8000, {32'h44, 32'h33, 32'h22, 32'h11}, 32'hB0, 1'b0, sc);
    chk("dirty_stall_cycles", 64'(sc), 64'd14);
    chk("dirty_first_addr", 64'(first_addr), 64'h8000);
    chk("dirty_first_wdata", 64'(first_wdata), 64'h11);
    chk("dirty_line_addr", 64'(last_done_addr), 64'h2460);

    // Backpressure on writeback word 2 for three cycles.
    bp_addr = 32'h9008;
    bp_left = 3;
    run_miss(1'b0, 32'h3000, 1'b1, 32'h9000, {32'h5D, 32'h5C, 32'h5B, 32'h5A}, 32'hC0, 1'b0, sc);
    chk("bp_stall_cycles", 64'(sc), 64'd17);
    chk("bp_consumed", 64'(bp_left), 64'd0);

    // Flush raised during the refill does not abort it.
    run_miss(1'b1, 32'h4444, 1'b0, 32'h0, 128'h0, 32'hD0, 1'b1, sc);
    chk("flushmid_stall_cycles", 64'(sc), 64'd10);
    chk("flushmid_line_addr", 64'(last_done_addr), 64'h4440);

    // Async reset while waiting for refill word 2.
    @(posedge CLK);
    #1;
    rsp_base = 32'hE0; r_valid = 1'b1; hit_i = 1'b0; Addr = 32'h5678; victim_dirty_i = 1'b0;
    r0 = n_rd_acc;
    for (int k = 0; k < 100 && n_rd_acc < r0 + 3; k++) @(negedge CLK);
    if (n_rd_acc < r0 + 3) chk("reset_test_timeout", 64'd0, 64'd1);
    @(posedge CLK);
    #2 RESET = 1'b0;
    @(negedge CLK);
    chk("reset_mid_refill_we", 64'(refill_we_o), 64'd0);
    chk("reset_mid_stall", 64'(stall_o), 64'd0);
    @(posedge CLK);
    #1 RESET = 1'b1; r_valid = 1'b0;
    repeat (2) @(negedge CLK);

    run_miss(1'b1, 32'h40, 1'b0, 32'h0, 128'h0, 32'hF0, 1'b0, sc);
    chk("post_reset_first_addr", 64'(first_addr), 64'h40);
    chk("post_reset_stall_cycles", 64'(sc), 64'd10);

    repeat (3) @(negedge CLK);
    chk("end_queues_empty", 64'(exp_req.size() + exp_fill.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
